// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
// Holds FSM encoding, default bus widths and the latency counter type.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam int ADDR_W_DEF = 32;
    localparam int LINE_W_DEF = 128;
    localparam int CNT_W      = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    function automatic cnt_t lat_load(input int lat);
        return cnt_t'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of fetch, data and memory-side signals around the arbiter.
// master is the arbiter's view, slave the requesters' and memory's view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LINE_W = LINE_W_DEF
);

    logic              i_req;
    logic              i_abort;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic [LINE_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic              d_ready;
    logic [LINE_W-1:0] d_rdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;

    modport master (
        input  i_req, i_abort, i_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  mem_rdata,
        output i_ready, i_rdata,
        output d_ready, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_abort, i_addr,
        output d_req, d_we, d_addr, d_wdata,
        output mem_rdata,
        input  i_ready, i_rdata,
        input  d_ready, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter: data port over fetch port onto one memory.
// One transaction at a time; every output is a register.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY = 5,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int LINE_W      = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_abort,
    output logic              i_ready,
    output logic [LINE_W-1:0] i_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [LINE_W-1:0] d_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata
);

    localparam cnt_t LOAD = lat_load(MEM_LATENCY);

    arb_state_e state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic       abort_q, abort_d;

    logic              mem_req_d;
    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_d;
    logic              i_ready_d;
    logic              d_ready_d;
    logic [LINE_W-1:0] i_rdata_d;
    logic [LINE_W-1:0] d_rdata_d;

    logic last;
    logic fetch_dead;

    assign last       = (cnt_q == '0);
    assign fetch_dead = abort_q | i_abort;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        abort_d     = abort_q;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;
        i_rdata_d   = i_rdata;
        d_rdata_d   = d_rdata;

        unique case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d     = BUSY_D;
                    cnt_d       = LOAD;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                end else if (i_req && !i_abort) begin
                    state_d     = BUSY_I;
                    cnt_d       = LOAD;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wdata_d = '0;
                end
            end

            BUSY_I: begin
                if (i_abort) begin
                    abort_d = 1'b1;
                end
                if (last) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    // A flushed fetch still drains memory but never lands.
                    if (!fetch_dead) begin
                        i_rdata_d = mem_rdata;
                        i_ready_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end

            BUSY_D: begin
                if (last) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    d_ready_d = 1'b1;
                    if (!mem_we) begin
                        d_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end

            RESP: begin
                state_d = IDLE;
                abort_d = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ready   <= 1'b0;
            d_ready   <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            i_ready   <= i_ready_d;
            d_ready   <= d_ready_d;
            i_rdata   <= i_rdata_d;
            d_rdata   <= d_rdata_d;
        end
    end

endmodule
